ecc_scrub_arb: RTL and testbench
================================

ECC_SCRUB_ARB -- requirements
Module: ecc_scrub_arb

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, meaning memory address width; depth = 2**ADDR_WIDTH.
REQ-002 SHALL have parameter MEMORY_DATA_WIDTH, default 39, meaning SECDED codeword width.
REQ-003 SHALL have parameter SCRUB_INTERVAL, default 1024, meaning idle cycles between scrub words; minimum 1.
REQ-004 SHALL have parameter CNT_WIDTH, default 8, meaning error counter width.
REQ-005 One clock; reset is asynchronous and active-high: clk_i  input  1  clock; rst_i  input  1  async active-high reset.
REQ-006 scrub_en_i  input  1  enables background scrubbing.
REQ-007 cnt_clr_i  input  1  synchronous clear of both error counters.
REQ-008 fifo_wr_en_i / fifo_wr_addr_i / fifo_wr_data_i  input  1 / ADDR_WIDTH / MEMORY_DATA_WIDTH  encoded FIFO write request.
REQ-009 fifo_rd_en_i / fifo_rd_addr_i  input  1 / ADDR_WIDTH  FIFO read request.
REQ-010 mem_wr_en_o / mem_wr_addr_o / mem_wr_data_o  output  1 / ADDR_WIDTH / MEMORY_DATA_WIDTH  memory write port.
REQ-011 mem_rd_en_o / mem_rd_addr_o  output  1 / ADDR_WIDTH  memory read port; read data returns one cycle after mem_rd_en_o.
REQ-012 dec_sbe_i / dec_dbe_i / dec_corr_data_i  input  1 / 1 / MEMORY_DATA_WIDTH  decoder flags and corrected codeword for current read data (combinational from memory data).
REQ-013 scrub_busy_o  output  1  high in any state other than IDLE.
REQ-014 sbe_cnt_o / dbe_cnt_o  output  CNT_WIDTH  saturating scrub-detected single/double error counts.
REQ-015 dbe_irq_o  output  1  one-cycle pulse on scrub-detected double error.
REQ-016 pass_done_o  output  1  one-cycle pulse when scrub address wraps from depth-1 to 0.

Function
REQ-017 FSM states: IDLE, WAIT, RD, CHK, WB; IDLE->WAIT when scrub_en_i=1.
REQ-018 WAIT: interval counter counts to SCRUB_INTERVAL-1, then ->RD; counter cleared on entry.
REQ-019 RD: issue scrub read at scrub_addr only when fifo_rd_en_i=0; else hold RD; on issue ->CHK.
REQ-020 FIFO reads pass combinationally to memory read port with strict priority over scrub reads.
REQ-021 CHK (data cycle): dec_sbe_i=1 -> increment sbe_cnt, latch dec_corr_data_i, ->WB; dec_dbe_i=1 -> increment dbe_cnt, pulse dbe_irq_o, no writeback, advance; clean -> advance.
REQ-022 WB: write latched corrected word to scrub_addr only when fifo_wr_en_i=0; else hold WB; then advance.
REQ-023 FIFO writes pass combinationally to memory write port with strict priority over scrub writeback.
REQ-024 Collision: fifo_wr_en_i=1 with fifo_wr_addr_i=scrub_addr while in CHK or WB SHALL cancel the pending writeback (count still taken).
REQ-025 Advance: scrub_addr increments modulo depth; wrap to 0 pulses pass_done_o; next state WAIT if scrub_en_i=1 else IDLE.
REQ-026 scrub_en_i deassert mid-word SHALL complete the current word through CHK/WB before IDLE; in WAIT returns to IDLE next cycle.
REQ-027 Counters saturate at all-ones; cnt_clr_i wins over simultaneous increment.
REQ-028 Memory port outputs SHALL be zero data/address when corresponding enable is low.

Reset
REQ-029 rst_i asserted SHALL immediately force: state IDLE, scrub_addr 0, interval counter 0, both counters 0, all outputs 0; any in-flight writeback discarded.

Structure
REQ-030 Package ecc_scrub_pkg SHALL hold the state enum typedef and default parameter constants.
REQ-031 Sub-module sat_counter (parameterised width, inc, clr) SHALL be instantiated twice for sbe/dbe counts.

Verification
REQ-032 scrub_en_i=1, SCRUB_INTERVAL=4, no errors -> 32 reads addr 0..31, no writes, pass_done_o one pulse after addr 31.
REQ-033 dec_sbe_i=1 at addr 5 -> mem_wr_en_o with addr 5, data=dec_corr_data_i, sbe_cnt_o=1.
REQ-034 dec_dbe_i=1 at addr 9 -> dbe_irq_o one pulse, dbe_cnt_o=1, no write to addr 9.
REQ-035 fifo_rd_en_i held high 10 cycles during RD -> scrub read deferred 10 cycles; FIFO address on port each cycle.
REQ-036 SBE at addr 3 plus fifo_wr_en_i to addr 3 in WB -> only FIFO write occurs; 300 SBEs with CNT_WIDTH=8 -> sbe_cnt_o=255.
REQ-037 rst_i asserted in WB -> all outputs 0 same cycle; after release scrub restarts at addr 0.

Source files
------------

// File: rtl/ecc_scrub_pkg.sv
// ecc_scrub_pkg: shared types and default parameter values for the ECC
// background-scrub arbiter.
//   scrub_state_t : scrub FSM state encoding
//   DEF_*         : default values for the ecc_scrub_arb parameters
package ecc_scrub_pkg;

  localparam int unsigned DEF_ADDR_WIDTH        = 5;
  localparam int unsigned DEF_MEMORY_DATA_WIDTH = 39;
  localparam int unsigned DEF_SCRUB_INTERVAL    = 1024;
  localparam int unsigned DEF_CNT_WIDTH         = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_RD   = 3'd2,
    ST_CHK  = 3'd3,
    ST_WB   = 3'd4
  } scrub_state_t;

endpackage

// File: rtl/ecc_scrub_arb_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear.
//   clk   : clock
//   rst   : asynchronous active-high reset (count -> 0)
//   inc   : increment by one unless already all-ones
//   clr   : synchronous clear; takes precedence over inc
//   count : current count
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/ecc_scrub_arb.sv
// ecc_scrub_arb: arbitrates a single-port SECDED memory between a FIFO client
// and a background scrubber that reads every word, counts single/double
// errors and writes back corrected single-error words.
//   clk_i, rst_i            : clock, asynchronous active-high reset
//   scrub_en_i              : enable background scrubbing
//   cnt_clr_i               : synchronous clear of both error counters
//   fifo_wr_* / fifo_rd_*   : FIFO client requests (strict priority)
//   mem_wr_* / mem_rd_*     : memory ports (read data one cycle after mem_rd_en_o)
//   dec_sbe_i/dec_dbe_i     : decoder flags for the current read data
//   dec_corr_data_i         : corrected codeword for the current read data
//   scrub_busy_o            : scrubber not idle
//   sbe_cnt_o / dbe_cnt_o   : saturating scrub-detected error counts
//   dbe_irq_o               : one-cycle pulse on scrub-detected double error
//   pass_done_o             : one-cycle pulse when the scrub address wraps
module ecc_scrub_arb
  import ecc_scrub_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH        = DEF_ADDR_WIDTH,
  parameter int unsigned MEMORY_DATA_WIDTH = DEF_MEMORY_DATA_WIDTH,
  parameter int unsigned SCRUB_INTERVAL    = DEF_SCRUB_INTERVAL,
  parameter int unsigned CNT_WIDTH         = DEF_CNT_WIDTH
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         scrub_en_i,
  input  logic                         cnt_clr_i,
  input  logic                         fifo_wr_en_i,
  input  logic [ADDR_WIDTH-1:0]        fifo_wr_addr_i,
  input  logic [MEMORY_DATA_WIDTH-1:0] fifo_wr_data_i,
  input  logic                         fifo_rd_en_i,
  input  logic [ADDR_WIDTH-1:0]        fifo_rd_addr_i,
  output logic                         mem_wr_en_o,
  output logic [ADDR_WIDTH-1:0]        mem_wr_addr_o,
  output logic [MEMORY_DATA_WIDTH-1:0] mem_wr_data_o,
  output logic                         mem_rd_en_o,
  output logic [ADDR_WIDTH-1:0]        mem_rd_addr_o,
  input  logic                         dec_sbe_i,
  input  logic                         dec_dbe_i,
  input  logic [MEMORY_DATA_WIDTH-1:0] dec_corr_data_i,
  output logic                         scrub_busy_o,
  output logic [CNT_WIDTH-1:0]         sbe_cnt_o,
  output logic [CNT_WIDTH-1:0]         dbe_cnt_o,
  output logic                         dbe_irq_o,
  output logic                         pass_done_o
);

  localparam int unsigned IW = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;
  localparam logic [IW-1:0] IVL_LAST = IW'(SCRUB_INTERVAL - 1);

  scrub_state_t                 state, state_nxt;
  logic [ADDR_WIDTH-1:0]        scrub_addr;
  logic [IW-1:0]                ivl_cnt;
  logic [MEMORY_DATA_WIDTH-1:0] wb_data;
  logic                         dbe_irq_q, pass_done_q;
  logic                         collision, advance, latch_wb;
  logic                         scrub_rd, scrub_wr, sbe_inc, dbe_inc;

  // A FIFO write to the word being scrubbed supersedes the pending writeback.
  assign collision = fifo_wr_en_i && (fifo_wr_addr_i == scrub_addr) &&
                     ((state == ST_CHK) || (state == ST_WB));

  always_comb begin
    state_nxt = state;
    advance   = 1'b0;
    latch_wb  = 1'b0;
    scrub_rd  = 1'b0;
    scrub_wr  = 1'b0;
    sbe_inc   = 1'b0;
    dbe_inc   = 1'b0;
    case (state)
      ST_IDLE: if (scrub_en_i) state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (!scrub_en_i)              state_nxt = ST_IDLE;
        else if (ivl_cnt == IVL_LAST) state_nxt = ST_RD;
      end
      ST_RD: begin
        if (!fifo_rd_en_i) begin
          scrub_rd  = 1'b1;
          state_nxt = ST_CHK;
        end
      end
      ST_CHK: begin
        if (dec_sbe_i) begin
          sbe_inc = 1'b1;
          if (collision) begin
            advance = 1'b1;
          end else begin
            latch_wb  = 1'b1;
            state_nxt = ST_WB;
          end
        end else if (dec_dbe_i) begin
          dbe_inc = 1'b1;
          advance = 1'b1;
        end else begin
          advance = 1'b1;
        end
      end
      ST_WB: begin
        if (collision) begin
          advance = 1'b1;
        end else if (!fifo_wr_en_i) begin
          scrub_wr = 1'b1;
          advance  = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (advance) state_nxt = scrub_en_i ? ST_WAIT : ST_IDLE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      scrub_addr  <= '0;
      ivl_cnt     <= '0;
      wb_data     <= '0;
      dbe_irq_q   <= 1'b0;
      pass_done_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      // Counter only runs while staying in WAIT, so it is zero on every entry.
      ivl_cnt     <= ((state == ST_WAIT) && (state_nxt == ST_WAIT)) ? ivl_cnt + IW'(1) : '0;
      dbe_irq_q   <= dbe_inc;
      pass_done_q <= advance && (scrub_addr == '1);
      if (advance)  scrub_addr <= scrub_addr + ADDR_WIDTH'(1);
      if (latch_wb) wb_data    <= dec_corr_data_i;
    end
  end

  // Memory ports: FIFO has strict priority; everything is zero under reset
  // or when the corresponding enable is low.
  always_comb begin
    mem_wr_en_o   = 1'b0;
    mem_wr_addr_o = '0;
    mem_wr_data_o = '0;
    mem_rd_en_o   = 1'b0;
    mem_rd_addr_o = '0;
    if (!rst_i) begin
      if (fifo_wr_en_i) begin
        mem_wr_en_o   = 1'b1;
        mem_wr_addr_o = fifo_wr_addr_i;
        mem_wr_data_o = fifo_wr_data_i;
      end else if (scrub_wr) begin
        mem_wr_en_o   = 1'b1;
        mem_wr_addr_o = scrub_addr;
        mem_wr_data_o = wb_data;
      end
      if (fifo_rd_en_i) begin
        mem_rd_en_o   = 1'b1;
        mem_rd_addr_o = fifo_rd_addr_i;
      end else if (scrub_rd) begin
        mem_rd_en_o   = 1'b1;
        mem_rd_addr_o = scrub_addr;
      end
    end
  end

  assign scrub_busy_o = (state != ST_IDLE);
  assign dbe_irq_o    = dbe_irq_q;
  assign pass_done_o  = pass_done_q;

  sat_counter #(.WIDTH(CNT_WIDTH)) u_sbe_cnt (
    .clk   (clk_i),
    .rst   (rst_i),
    .inc   (sbe_inc),
    .clr   (cnt_clr_i),
    .count (sbe_cnt_o)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_dbe_cnt (
    .clk   (clk_i),
    .rst   (rst_i),
    .inc   (dbe_inc),
    .clr   (cnt_clr_i),
    .count (dbe_cnt_o)
  );

endmodule

// File: tb/tb_ecc_scrub_arb.sv
// tb_ecc_scrub_arb: directed self-checking bench for ecc_scrub_arb with a
// small memory/decoder model that flags chosen addresses as single or
// double errors one cycle after they are read.
module tb_ecc_scrub_arb;

  localparam int unsigned AW  = 5;
  localparam int unsigned DW  = 39;
  localparam int unsigned IVL = 4;
  localparam int unsigned CW  = 8;

  logic          clk = 1'b0;
  logic          rst, scrub_en, cnt_clr;
  logic          fifo_wr_en, fifo_rd_en;
  logic [AW-1:0] fifo_wr_addr, fifo_rd_addr;
  logic [DW-1:0] fifo_wr_data;
  logic          mem_wr_en, mem_rd_en;
  logic [AW-1:0] mem_wr_addr, mem_rd_addr;
  logic [DW-1:0] mem_wr_data;
  logic          dec_sbe, dec_dbe;
  logic [DW-1:0] dec_corr_data;
  logic          busy, dbe_irq, pass_done;
  logic [CW-1:0] sbe_cnt, dbe_cnt;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic [31:0]   sbe_mask = '0;
  logic [31:0]   dbe_mask = '0;
  logic          rd_v_q = 1'b0;
  logic [AW-1:0] rd_a_q = '0;

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] corr(input logic [AW-1:0] a);
    return {34'h1_2345_6789, a};
  endfunction

  always @(posedge clk) begin
    rd_v_q <= mem_rd_en;
    rd_a_q <= mem_rd_addr;
  end

  assign dec_sbe       = rd_v_q & sbe_mask[rd_a_q];
  assign dec_dbe       = rd_v_q & dbe_mask[rd_a_q];
  assign dec_corr_data = corr(rd_a_q);

  ecc_scrub_arb #(
    .ADDR_WIDTH        (AW),
    .MEMORY_DATA_WIDTH (DW),
    .SCRUB_INTERVAL    (IVL),
    .CNT_WIDTH         (CW)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .scrub_en_i      (scrub_en),
    .cnt_clr_i       (cnt_clr),
    .fifo_wr_en_i    (fifo_wr_en),
    .fifo_wr_addr_i  (fifo_wr_addr),
    .fifo_wr_data_i  (fifo_wr_data),
    .fifo_rd_en_i    (fifo_rd_en),
    .fifo_rd_addr_i  (fifo_rd_addr),
    .mem_wr_en_o     (mem_wr_en),
    .mem_wr_addr_o   (mem_wr_addr),
    .mem_wr_data_o   (mem_wr_data),
    .mem_rd_en_o     (mem_rd_en),
    .mem_rd_addr_o   (mem_rd_addr),
    .dec_sbe_i       (dec_sbe),
    .dec_dbe_i       (dec_dbe),
    .dec_corr_data_i (dec_corr_data),
    .scrub_busy_o    (busy),
    .sbe_cnt_o       (sbe_cnt),
    .dbe_cnt_o       (dbe_cnt),
    .dbe_irq_o       (dbe_irq),
    .pass_done_o     (pass_done)
  );

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; scrub_en = 1'b0; cnt_clr = 1'b0;
    fifo_wr_en = 1'b0; fifo_wr_addr = '0; fifo_wr_data = '0;
    fifo_rd_en = 1'b0; fifo_rd_addr = '0;
    sbe_mask = '0; dbe_mask = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Waits (bounded) for a negedge where the scrubber drives the write port.
  task automatic wait_scrub_wr(input int bound, output bit found);
    found = 1'b0;
    for (int c = 0; c < bound; c++) begin
      @(negedge clk);
      if (mem_wr_en && !fifo_wr_en) begin found = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; scrub_en = 1'b1; cnt_clr = 1'b0;
    fifo_wr_en = 1'b1; fifo_wr_addr = 5'd7; fifo_wr_data = 39'h5;
    fifo_rd_en = 1'b1; fifo_rd_addr = 5'd9;
    #13;
    n_tests++; if (mem_wr_en !== 1'b0) begin n_fail++; $display("FAIL rst_wr_en got %b exp 0", mem_wr_en); end
    n_tests++; if (mem_wr_addr !== '0) begin n_fail++; $display("FAIL rst_wr_addr got %0h exp 0", mem_wr_addr); end
    n_tests++; if (mem_wr_data !== '0) begin n_fail++; $display("FAIL rst_wr_data got %0h exp 0", mem_wr_data); end
    n_tests++; if (mem_rd_en !== 1'b0) begin n_fail++; $display("FAIL rst_rd_en got %b exp 0", mem_rd_en); end
    n_tests++; if (mem_rd_addr !== '0) begin n_fail++; $display("FAIL rst_rd_addr got %0h exp 0", mem_rd_addr); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b exp 0", busy); end
    n_tests++; if (sbe_cnt !== '0 || dbe_cnt !== '0) begin n_fail++; $display("FAIL rst_cnts got %0d/%0d exp 0/0", sbe_cnt, dbe_cnt); end
    n_tests++; if (dbe_irq !== 1'b0 || pass_done !== 1'b0) begin n_fail++; $display("FAIL rst_pulses got %b/%b exp 0/0", dbe_irq, pass_done); end
    do_reset();
    fifo_wr_en = 1'b1; fifo_wr_addr = 5'd7; fifo_wr_data = 39'h5;
    #1;
    n_tests++; if (mem_wr_en !== 1'b1 || mem_wr_addr !== 5'd7 || mem_wr_data !== 39'h5) begin
      n_fail++; $display("FAIL fifo_wr_pass got %b/%0h/%0h exp 1/7/5", mem_wr_en, mem_wr_addr, mem_wr_data); end
    n_tests++; if (mem_rd_en !== 1'b0 || mem_rd_addr !== '0) begin
      n_fail++; $display("FAIL idle_rd_zero got %b/%0h exp 0/0", mem_rd_en, mem_rd_addr); end
    fifo_wr_en = 1'b0; fifo_wr_addr = '0; fifo_wr_data = '0;
  endtask

  task automatic test_clean_pass();
    int unsigned idx = 0, writes = 0, pass_idx = 0;
    bit seen = 1'b0;
    do_reset();
    scrub_en = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (mem_rd_en) begin
        n_tests++;
        if (mem_rd_addr !== idx[AW-1:0]) begin n_fail++; $display("FAIL pass_rd_addr got %0d exp %0d", mem_rd_addr, idx); end
        idx++;
      end
      if (mem_wr_en) writes++;
      if (pass_done) begin seen = 1'b1; pass_idx = idx; break; end
    end
    n_tests++; if (!seen) begin n_fail++; $display("FAIL pass_done_timeout got 0 exp 1"); end
    n_tests++; if (pass_idx != 32) begin n_fail++; $display("FAIL pass_done_after got %0d reads exp 32", pass_idx); end
    n_tests++; if (writes != 0) begin n_fail++; $display("FAIL pass_writes got %0d exp 0", writes); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL pass_busy got %b exp 1", busy); end
    scrub_en = 1'b0;
    @(negedge clk);
    n_tests++; if (pass_done !== 1'b0) begin n_fail++; $display("FAIL pass_pulse_width got %b exp 0", pass_done); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wait_disable_idle got %b exp 0", busy); end
  endtask

  task automatic test_sbe();
    int unsigned writes = 0;
    logic [AW-1:0] wa = '0;
    logic [DW-1:0] wd = '0;
    bit done = 1'b0;
    do_reset();
    sbe_mask[5] = 1'b1;
    scrub_en = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (mem_wr_en) begin writes++; wa = mem_wr_addr; wd = mem_wr_data; end
      if (mem_rd_en && mem_rd_addr == 5'd7) begin done = 1'b1; break; end
    end
    n_tests++; if (!done) begin n_fail++; $display("FAIL sbe_timeout got 0 exp 1"); end
    n_tests++; if (writes != 1) begin n_fail++; $display("FAIL sbe_writes got %0d exp 1", writes); end
    n_tests++; if (wa !== 5'd5 || wd !== corr(5'd5)) begin n_fail++; $display("FAIL sbe_wb got %0h/%0h exp 5/%0h", wa, wd, corr(5'd5)); end
    n_tests++; if (sbe_cnt !== 8'd1 || dbe_cnt !== 8'd0) begin n_fail++; $display("FAIL sbe_cnts got %0d/%0d exp 1/0", sbe_cnt, dbe_cnt); end
  endtask

  task automatic test_dbe();
    int unsigned writes = 0, irqs = 0;
    bit done = 1'b0;
    do_reset();
    dbe_mask[9] = 1'b1;
    scrub_en = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (mem_wr_en) writes++;
      if (dbe_irq) irqs++;
      if (mem_rd_en && mem_rd_addr == 5'd11) begin done = 1'b1; break; end
    end
    n_tests++; if (!done) begin n_fail++; $display("FAIL dbe_timeout got 0 exp 1"); end
    n_tests++; if (irqs != 1) begin n_fail++; $display("FAIL dbe_irq_pulses got %0d exp 1", irqs); end
    n_tests++; if (writes != 0) begin n_fail++; $display("FAIL dbe_writes got %0d exp 0", writes); end
    n_tests++; if (dbe_cnt !== 8'd1 || sbe_cnt !== 8'd0) begin n_fail++; $display("FAIL dbe_cnts got %0d/%0d exp 1/0", dbe_cnt, sbe_cnt); end
  endtask

  task automatic test_disable_mid_word();
    bit found = 1'b0;
    do_reset();
    sbe_mask[0] = 1'b1;
    scrub_en = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (mem_rd_en) begin found = 1'b1; break; end
    end
    n_tests++; if (!found) begin n_fail++; $display("FAIL mid_rd_timeout got 0 exp 1"); end
    scrub_en = 1'b0;
    @(negedge clk);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_chk_busy got %b exp 1", busy); end
    @(negedge clk);
    n_tests++; if (mem_wr_en !== 1'b1 || mem_wr_addr !== 5'd0 || mem_wr_data !== corr(5'd0)) begin
      n_fail++; $display("FAIL mid_wb got %b/%0h/%0h exp 1/0/%0h", mem_wr_en, mem_wr_addr, mem_wr_data, corr(5'd0)); end
    @(negedge clk);
    n_tests++; if (busy !== 1'b0 || mem_wr_en !== 1'b0) begin n_fail++; $display("FAIL mid_idle got %b/%b exp 0/0", busy, mem_wr_en); end
  endtask

  task automatic test_fifo_rd_priority();
    bit found = 1'b0;
    do_reset();
    scrub_en = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (mem_rd_en) begin found = 1'b1; break; end
    end
    n_tests++; if (!found) begin n_fail++; $display("FAIL rdp_timeout got 0 exp 1"); end
    fifo_rd_en = 1'b1; fifo_rd_addr = 5'h1A;
    for (int c = 0; c < 10; c++) begin
      #1;
      n_tests++; if (mem_rd_en !== 1'b1 || mem_rd_addr !== 5'h1A) begin
        n_fail++; $display("FAIL rdp_fifo cycle %0d got %b/%0h exp 1/1a", c, mem_rd_en, mem_rd_addr); end
      @(negedge clk);
    end
    fifo_rd_en = 1'b0; fifo_rd_addr = '0;
    #1;
    n_tests++; if (mem_rd_en !== 1'b1 || mem_rd_addr !== 5'd0) begin
      n_fail++; $display("FAIL rdp_deferred got %b/%0h exp 1/0", mem_rd_en, mem_rd_addr); end
    @(negedge clk);
    n_tests++; if (mem_rd_en !== 1'b0) begin n_fail++; $display("FAIL rdp_single_issue got %b exp 0", mem_rd_en); end
  endtask

  task automatic test_wb_hold();
    bit found;
    do_reset();
    sbe_mask[2] = 1'b1;
    scrub_en = 1'b1;
    wait_scrub_wr(100, found);
    n_tests++; if (!found) begin n_fail++; $display("FAIL hold_timeout got 0 exp 1"); end
    fifo_wr_en = 1'b1; fifo_wr_addr = 5'd20; fifo_wr_data = 39'h7F_0000_00AA;
    repeat (2) begin
      #1;
      n_tests++; if (mem_wr_addr !== 5'd20 || mem_wr_data !== 39'h7F_0000_00AA) begin
        n_fail++; $display("FAIL hold_fifo_wr got %0h/%0h exp 14/7f000000aa", mem_wr_addr, mem_wr_data); end
      @(negedge clk);
    end
    fifo_wr_en = 1'b0; fifo_wr_addr = '0; fifo_wr_data = '0;
    #1;
    n_tests++; if (mem_wr_en !== 1'b1 || mem_wr_addr !== 5'd2 || mem_wr_data !== corr(5'd2)) begin
      n_fail++; $display("FAIL hold_wb got %b/%0h/%0h exp 1/2/%0h", mem_wr_en, mem_wr_addr, mem_wr_data, corr(5'd2)); end
    @(negedge clk);
    n_tests++; if (mem_wr_en !== 1'b0) begin n_fail++; $display("FAIL hold_after got %b exp 0", mem_wr_en); end
  endtask

  task automatic test_collision();
    bit found;
    int unsigned writes = 0;
    bit done = 1'b0;
    do_reset();
    sbe_mask[3] = 1'b1;
    scrub_en = 1'b1;
    wait_scrub_wr(100, found);
    n_tests++; if (!found || mem_wr_addr !== 5'd3) begin n_fail++; $display("FAIL col_wb_seen got %b/%0h exp 1/3", found, mem_wr_addr); end
    fifo_wr_en = 1'b1; fifo_wr_addr = 5'd3; fifo_wr_data = 39'h12_3456_789A;
    #1;
    n_tests++; if (mem_wr_addr !== 5'd3 || mem_wr_data !== 39'h12_3456_789A) begin
      n_fail++; $display("FAIL col_fifo_wr got %0h/%0h exp 3/123456789a", mem_wr_addr, mem_wr_data); end
    @(negedge clk);
    fifo_wr_en = 1'b0; fifo_wr_addr = '0; fifo_wr_data = '0;
    #1;
    n_tests++; if (mem_wr_en !== 1'b0) begin n_fail++; $display("FAIL col_cancel got %b exp 0", mem_wr_en); end
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (mem_wr_en) writes++;
      if (mem_rd_en && mem_rd_addr == 5'd5) begin done = 1'b1; break; end
    end
    n_tests++; if (!done || writes != 0) begin n_fail++; $display("FAIL col_no_wb got %b/%0d exp 1/0", done, writes); end
    n_tests++; if (sbe_cnt !== 8'd1) begin n_fail++; $display("FAIL col_cnt got %0d exp 1", sbe_cnt); end
  endtask

  task automatic test_saturate_clear();
    bit found = 1'b0;
    do_reset();
    sbe_mask = '1;
    scrub_en = 1'b1;
    repeat (2200) @(negedge clk);
    n_tests++; if (sbe_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_sbe got %0d exp 255", sbe_cnt); end
    n_tests++; if (dbe_cnt !== 8'd0) begin n_fail++; $display("FAIL sat_dbe got %0d exp 0", dbe_cnt); end
    for (int c = 0; c < 20; c++) begin
      if (dec_sbe) begin found = 1'b1; break; end
      @(negedge clk);
    end
    n_tests++; if (!found) begin n_fail++; $display("FAIL clr_chk_timeout got 0 exp 1"); end
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    n_tests++; if (sbe_cnt !== 8'd0) begin n_fail++; $display("FAIL clr_wins got %0d exp 0", sbe_cnt); end
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (dec_sbe) begin found = 1'b1; break; end
    end
    @(negedge clk);
    n_tests++; if (!found || sbe_cnt !== 8'd1) begin n_fail++; $display("FAIL clr_recount got %b/%0d exp 1/1", found, sbe_cnt); end
  endtask

  task automatic test_reset_in_wb();
    bit found;
    int unsigned writes = 0;
    bit done = 1'b0;
    do_reset();
    sbe_mask[1] = 1'b1;
    scrub_en = 1'b1;
    wait_scrub_wr(100, found);
    n_tests++; if (!found || sbe_cnt !== 8'd1) begin n_fail++; $display("FAIL rwb_setup got %b/%0d exp 1/1", found, sbe_cnt); end
    rst = 1'b1;
    #1;
    n_tests++; if (mem_wr_en !== 1'b0 || mem_wr_addr !== '0 || mem_wr_data !== '0) begin
      n_fail++; $display("FAIL rwb_wr_zero got %b/%0h/%0h exp 0/0/0", mem_wr_en, mem_wr_addr, mem_wr_data); end
    n_tests++; if (busy !== 1'b0 || sbe_cnt !== 8'd0 || mem_rd_en !== 1'b0) begin
      n_fail++; $display("FAIL rwb_state_zero got %b/%0d/%b exp 0/0/0", busy, sbe_cnt, mem_rd_en); end
    @(negedge clk);
    sbe_mask = '0;
    rst = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (mem_wr_en) writes++;
      if (mem_rd_en) begin done = 1'b1; break; end
    end
    n_tests++; if (!done || mem_rd_addr !== 5'd0) begin n_fail++; $display("FAIL rwb_restart got %b/%0h exp 1/0", done, mem_rd_addr); end
    n_tests++; if (writes != 0) begin n_fail++; $display("FAIL rwb_discard got %0d exp 0", writes); end
  endtask

  initial begin
    test_reset();
    test_clean_pass();
    test_sbe();
    test_dbe();
    test_disable_mid_word();
    test_fifo_rd_priority();
    test_wb_hold();
    test_collision();
    test_saturate_clear();
    test_reset_in_wb();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
